// File: rtl/skein1024_ubi_ctrl.sv
// UBI sequencer for Skein-1024-1024: drives one shared Threefish-1024 engine through
// the message chain and the output stage, building extended keys/tweaks and feed-forward.
module skein1024_ubi_ctrl #(
  parameter logic [1023:0] IV = {
    64'h1DE0536E8682E539, 64'h61FD3062D00A579A, 64'h6572DD22F2B4969A, 64'h0996753C10ED0BB8,
    64'h1A1F1DDE743F02D4, 64'h9243C60DCCFF1332, 64'h6A9B0BFC6EB67E0D, 64'hD6D14AF9C6329AB5,
    64'hC11E1DB524DCB0A3, 64'h77E2BDFDC6394ADA, 64'h6E510B8BCDD0589F, 64'h1CAEC6FD1983A898,
    64'h03BD41D3FCBCAFAF, 64'h5180E5AEBAF2C4F0, 64'h15B5E511AC73E00C, 64'hD593DA0741E72355},
  parameter bit OUTPUT_STAGE = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           msg_valid,
  output logic           msg_ready,
  input  logic [1023:0]  msg_data,
  input  logic           msg_last,
  input  logic [7:0]     msg_bytes,
  output logic           digest_valid,
  input  logic           digest_ready,
  output logic [1023:0]  digest,
  output logic           busy,
  output logic           eng_valid,
  output logic [1023:0]  eng_input,
  output logic [1087:0]  eng_key,
  output logic [191:0]   eng_type,
  input  logic [1023:0]  eng_output,
  input  logic           eng_done
);

  typedef enum logic [2:0] {
    IDLE, MSG_GO, MSG_GUARD, MSG_WAIT, OUT_GO, OUT_GUARD, OUT_WAIT, DIGEST
  } state_t;

  localparam logic [63:0] KS_PARITY = 64'h1BD11BDAA9FC1A22;
  localparam logic [63:0] OUT_T0    = 64'd8;
  localparam logic [63:0] OUT_T1    = 64'hFF00000000000000;

  function automatic logic [1087:0] ext_key(input logic [1023:0] c);
    logic [63:0] p;
    p = KS_PARITY;
    for (int i = 0; i < 16; i++) p ^= c[64*i +: 64];
    return {p, c};
  endfunction

  function automatic logic [191:0] ext_tweak(input logic [63:0] t0, input logic [63:0] t1);
    return {t0 ^ t1, t1, t0};
  endfunction

  state_t        state;
  logic [1023:0] chain, blk, blk_pad, chain_nxt;
  logic [95:0]   pos, pos_nxt;
  logic          first, fin;
  logic [63:0]   msg_t1;

  // Bytes at or beyond msg_bytes are zero-padded before entering the engine.
  always_comb begin
    blk_pad = '0;
    for (int k = 0; k < 128; k++)
      blk_pad[8*k +: 8] = (8'(k) < msg_bytes) ? msg_data[8*k +: 8] : 8'h00;
  end

  assign pos_nxt   = pos + 96'(msg_bytes);
  assign msg_t1    = {msg_last, first, 6'h30, 24'd0, pos_nxt[95:64]};
  assign chain_nxt = eng_output ^ blk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      chain        <= IV;
      blk          <= '0;
      pos          <= '0;
      first        <= 1'b1;
      fin          <= 1'b0;
      msg_ready    <= 1'b1;
      busy         <= 1'b0;
      digest_valid <= 1'b0;
      digest       <= '0;
      eng_valid    <= 1'b0;
      eng_input    <= '0;
      eng_key      <= '0;
      eng_type     <= '0;
    end else begin
      eng_valid <= 1'b0;
      case (state)
        IDLE: if (msg_valid && msg_ready) begin
          blk       <= blk_pad;
          pos       <= pos_nxt;
          first     <= 1'b0;
          fin       <= msg_last;
          eng_input <= blk_pad;
          eng_key   <= ext_key(chain);
          eng_type  <= ext_tweak(pos_nxt[63:0], msg_t1);
          eng_valid <= 1'b1;
          msg_ready <= 1'b0;
          busy      <= 1'b1;
          state     <= MSG_GO;
        end
        MSG_GO:    state <= MSG_GUARD;
        // The engine's done level may still belong to the previous job here.
        MSG_GUARD: state <= MSG_WAIT;
        MSG_WAIT: if (eng_done) begin
          chain <= chain_nxt;
          if (!fin) begin
            msg_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end else if (OUTPUT_STAGE) begin
            eng_input <= '0;
            eng_key   <= ext_key(chain_nxt);
            eng_type  <= ext_tweak(OUT_T0, OUT_T1);
            eng_valid <= 1'b1;
            state     <= OUT_GO;
          end else begin
            digest       <= chain_nxt;
            digest_valid <= 1'b1;
            state        <= DIGEST;
          end
        end
        OUT_GO:    state <= OUT_GUARD;
        OUT_GUARD: state <= OUT_WAIT;
        OUT_WAIT: if (eng_done) begin
          digest       <= eng_output;
          digest_valid <= 1'b1;
          state        <= DIGEST;
        end
        DIGEST: if (digest_ready) begin
          digest_valid <= 1'b0;
          msg_ready    <= 1'b1;
          busy         <= 1'b0;
          chain        <= IV;
          pos          <= '0;
          first        <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/skein1024_ubi_ctrl.md
# skein1024_ubi_ctrl

Sequences one shared `Skein1024Block` Threefish-1024 engine through a complete Skein-1024-1024 hash. It runs the UBI message chain over a stream of 128-byte blocks, then the output UBI stage. It builds the 1088-bit extended key and the 192-bit extended tweak, pads the final block, applies the UBI feed-forward XOR and returns a 1024-bit digest. The block sits between the message-fetch logic and the engine.

## Interface
- `IV`, 1024-bit Skein-1024-1024 chaining IV (Skein v1.3 Appendix B), initial chain value, word i at [64i+:64].
- `OUTPUT_STAGE`, 1, 1 runs the output UBI; 0 returns the raw message chain as the digest.
- `clk`  in  1  clock, all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `msg_valid`  in  1  message block offered.
- `msg_ready`  out  1  controller can accept a block.
- `msg_data`  in  1024  block bytes; byte k at [8k+:8].
- `msg_last`  in  1  final block of the message.
- `msg_bytes`  in  8  valid bytes. Must be 128 unless `msg_last`; 0..128 when last; 0 only for the empty message.
- `digest_valid`  out  1  digest available.
- `digest_ready`  in  1  consumer takes the digest.
- `digest`  out  1024  hash result.
- `busy`  out  1  high in every state except IDLE.
- `eng_valid`  out  1  one-cycle start pulse (engine `DataValid`).
- `eng_input`  out  1024  plaintext to the engine.
- `eng_key`  out  1088  words 0..15 = chain; word 16 at [1087:1024] = 0x1BD11BDAA9FC1A22 ^ XOR(words 0..15).
- `eng_type`  out  192  t0 [63:0], t1 [127:64], t2 [191:128] = t0^t1.
- `eng_output`  in  1024  raw Threefish output (no feed-forward).
- `eng_done`  in  1  engine completion (engine `CompletedSig`, level).

## Operation
- **State machine:** IDLE, MSG_GO, MSG_GUARD, MSG_WAIT, OUT_GO, OUT_GUARD, OUT_WAIT, DIGEST.
- **IDLE:**
  - `msg_ready` = 1.
  - On `msg_valid & msg_ready`, register the padded block: bytes ≥ `msg_bytes` forced to 0.
  - Advance the 96-bit position `pos += msg_bytes`.
  - Latch `first` = no prior block since reset or digest; latch `final` = `msg_last`.
  - Go to MSG_GO.
- **MSG_GO:** `eng_valid` = 1, then MSG_GUARD.
- **MSG_GUARD:** one cycle in which `eng_done` is ignored, so a stale level from the previous job is never taken. Then MSG_WAIT.
- **MSG_WAIT:** on `eng_done`, set chain ← `eng_output ^ block`.
  - If not final, go to IDLE.
  - If final, go to OUT_GO when `OUTPUT_STAGE`=1, else to DIGEST.
- **Message tweak:**
  - t0 = pos[63:0].
  - t1[31:0] = pos[95:64]; t1[61:56] = 0x30; t1[62] = first; t1[63] = final; all other bits 0.
- **Output stage:**
  - `eng_input` = 0.
  - `eng_type`: t0 = 8, t1 = 0xFF00000000000000.
  - OUT_GO, OUT_GUARD and OUT_WAIT mirror the message states.
  - Result is `eng_output` (XOR with 0); go to DIGEST.
- **DIGEST:** `digest_valid` = 1 and `digest` stable until `digest_ready`. Then chain ← IV, pos ← 0, first ← 1, go to IDLE.
- **Engine port holding:** `eng_input`, `eng_key` and `eng_type` are registered and stay constant from MSG_GO/OUT_GO until `eng_done` is sampled.
- **Position counter:** wraps modulo 2^96 with no error flag.
- **Empty message:** `msg_bytes`=0 with `msg_last` processes one all-zero block with pos = 0, first = final = 1.

## Timing
- **Reset values:**
  - state IDLE; `msg_ready` 1; `eng_valid` 0; `digest_valid` 0; `busy` 0.
  - `digest` 0; `eng_*` buses 0; chain = IV; pos 0; first 1.
- **Reset mid-operation:** any in-flight result is abandoned. The engine has no reset, so `rst` must be held for at least one full engine latency.
- **Launch latency:** acceptance edge to `eng_valid` high is 1 cycle.
- **Completion latency:** `eng_done` sampled to `msg_ready` high (next block) is 1 cycle.
- **Earliest sample:** `eng_done` is sampled no earlier than 2 cycles after the `eng_valid` pulse.
- **Digest latency:** last `eng_done` to `digest_valid` is 1 cycle.
- **Digest handshake:** `digest_valid` drops the cycle after `digest_ready` is sampled high, and `msg_ready` rises on that same cycle.
- **Acceptance gating:** `msg_valid` is ignored outside IDLE. A block offered in the same cycle the digest is taken is not accepted until IDLE.

## Test plan
- **Single full block, first launch:** `IV`=1024'h5663952F…72F001CA5A4352BE62092156; one 128-byte non-last block -> at `eng_valid`:
  - `eng_key[1087:1024]` = 64'h11409CDB9691AEBB.
  - `eng_type` = 192'h7000000000000080_7000000000000000_0000000000000080.
- **Real engine feed-forward:** attach the real engine with input A6D8A0A6…A446FA31 and the same key -> `eng_output` = 90784118…5AF404, and the new chain = that value XOR input.
- **Two-block message (mock engine):** 128 bytes then a last block of 5 bytes ->
  - second tweak t0 = 0x85, t1 = 0xB000000000000000.
  - second block bytes 5..127 = 0.
  - output tweak t0 = 8, t1 = 0xFF00000000000000.
- **Empty message:** `msg_bytes`=0 with `msg_last` -> t0 = 0, t1 = 0xF000000000000000, `eng_input` = 0, two engine launches, then `digest_valid`.
- **Stale done and backpressure:** `eng_done` held high from the prior job and `digest_ready` low for 10 cycles -> no early chain update; `digest` stable; `msg_ready` = 0 throughout.
- **Reset mid-hash:** assert `rst` in MSG_WAIT -> all outputs at reset values; the next message hashes identically to a fresh run.
